// File: rtl/gray_tracker_pkg.sv
// Shared types and helpers for the gray-code receive tracker.
package gray_tracker_pkg;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } state_t;

   // Largest code a width-bit word can hold; the step from this value to 0 is a wrap.
   function automatic int unsigned max_code(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/gray_tracker_if.sv
// Sample/status bundle between a gray-code source side and the tracker.
interface gray_tracker_if #(
   parameter int WIDTH     = 3,
   parameter int CNT_WIDTH = 8,
   parameter int ERR_WIDTH = 4
);
   logic                 clear;
   logic                 valid;
   logic [WIDTH-1:0]     gray_in;
   logic [WIDTH-1:0]     binary;
   logic                 locked;
   logic                 wrap;
   logic                 error;
   logic [CNT_WIDTH-1:0] wrap_count;
   logic [ERR_WIDTH-1:0] err_count;

   modport master (
      output clear, valid, gray_in,
      input  binary, locked, wrap, error, wrap_count, err_count
   );

   modport slave (
      input  clear, valid, gray_in,
      output binary, locked, wrap, error, wrap_count, err_count
   );
endinterface

// File: rtl/gray_tracker_gray2bin.sv
// Combinational gray-to-binary decoder (gray2bin).
module gray_tracker_gray2bin #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   // Each binary bit is the XOR of its gray bit and every gray bit above it;
   // written as a reduction so no output bit depends on another output bit.
   always_comb begin
      bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
         bin[i] = ^(gray >> i);
      end
   end

endmodule

// File: rtl/gray_tracker.sv
// Gray-code receive tracker: decodes sampled gray words, checks that they
// step by +1 or hold, and reports wraps and illegal steps.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   UNLOCKED | no reference yet; next valid sample becomes the reference
//   LOCKED   | reference held in binary; each valid sample is step-checked
module gray_tracker
   import gray_tracker_pkg::*;
#(
   parameter int WIDTH     = 3,
   parameter int CNT_WIDTH = 8,
   parameter int ERR_WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   gray_tracker_if.slave bus
);

   localparam logic [WIDTH-1:0]     MAX_CODE = WIDTH'(max_code(WIDTH));
   localparam logic [ERR_WIDTH-1:0] ERR_SAT  = '1;

   state_t               state;
   logic [WIDTH-1:0]     d;
   logic [WIDTH-1:0]     bin_inc;
   logic [WIDTH-1:0]     binary_q;
   logic                 locked_q;
   logic                 wrap_q;
   logic                 error_q;
   logic [CNT_WIDTH-1:0] wrap_count_q;
   logic [ERR_WIDTH-1:0] err_count_q;

   gray_tracker_gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
      .gray (bus.gray_in),
      .bin  (d)
   );

   // Expected next value; wraps naturally in WIDTH bits.
   assign bin_inc = binary_q + WIDTH'(1);

   // Lock FSM with step check, pulse and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= UNLOCKED;
         binary_q     <= '0;
         locked_q     <= 1'b0;
         wrap_q       <= 1'b0;
         error_q      <= 1'b0;
         wrap_count_q <= '0;
         err_count_q  <= '0;
      end else if (bus.clear) begin
         state        <= UNLOCKED;
         binary_q     <= '0;
         locked_q     <= 1'b0;
         wrap_q       <= 1'b0;
         error_q      <= 1'b0;
         wrap_count_q <= '0;
         err_count_q  <= '0;
      end else begin
         wrap_q  <= 1'b0;
         error_q <= 1'b0;
         if (bus.valid) begin
            case (state)
               UNLOCKED: begin
                  binary_q <= d;
                  locked_q <= 1'b1;
                  state    <= LOCKED;
               end
               LOCKED: begin
                  if (d == bin_inc) begin
                     binary_q <= d;
                     if (binary_q == MAX_CODE) begin
                        wrap_q       <= 1'b1;
                        wrap_count_q <= wrap_count_q + CNT_WIDTH'(1);
                     end
                  end else if (d != binary_q) begin
                     // Resync to the new value so one glitch costs one error.
                     binary_q <= d;
                     error_q  <= 1'b1;
                     if (err_count_q != ERR_SAT) begin
                        err_count_q <= err_count_q + ERR_WIDTH'(1);
                     end
                  end
               end
               default: state <= UNLOCKED;
            endcase
         end
      end
   end

   assign bus.binary     = binary_q;
   assign bus.locked     = locked_q;
   assign bus.wrap       = wrap_q;
   assign bus.error      = error_q;
   assign bus.wrap_count = wrap_count_q;
   assign bus.err_count  = err_count_q;

endmodule
